poly_seq: RTL and testbench
===========================

POLY_SEQ -- requirements
Module: poly_seq

Interface
REQ-001 clk  in  1  rising-edge clock.
REQ-002 resetn  in  1  reset, synchronous, active-low; clock clk.
REQ-003 in_valid  in  1  operand word offered.
REQ-004 in_ready  out  1  operand accepted this cycle when in_valid&in_ready.
REQ-005 in_data  in  8  operand value, unsigned.
REQ-006 abort  in  1  synchronous cancel of current job.
REQ-007 out_valid  out  1  result available; held until taken.
REQ-008 out_ready  in  1  consumer takes result when out_valid&out_ready.
REQ-009 out_data  out  8  polynomial result, mod 256.
REQ-010 ovf  out  1  sticky: some intermediate of the current job exceeded 8 bits.
REQ-011 busy  out  1  high in CALC and DONE.

Function
REQ-012 Computes R = A*X^2 + B*X + C; operands accepted in order A, B, C, X, one per in handshake.
REQ-013 States: LOAD (in_ready=1, operand counter 0..N_OPERANDS-1), CALC (step counter 0..N_STEPS-1), DONE (out_valid=1).
REQ-014 LOAD->CALC on the handshake of the final operand (X); LOAD otherwise holds.
REQ-015 CALC executes Horner schedule, one ALU op per cycle into accumulator: acc=A; acc=acc*X; acc=acc+B; acc=acc*X; acc=acc+C.
REQ-016 Accumulator is initialised to A on its handshake; CALC uses exactly N_STEPS=4 cycles.
REQ-017 Latency: X accepted at edge k -> out_valid=1 and out_data valid from edge k+4 (k+6 with cubic).
REQ-018 in_ready=0 in CALC and DONE; in_valid ignored there.
REQ-019 DONE->LOAD on out handshake; out_data and ovf held stable while out_valid=1 and out_ready=0.
REQ-020 All arithmetic 8-bit wrap-around; ovf set when a sum carries out or a 16-bit product has nonzero bits [15:8].
REQ-021 ovf cleared on accepting A of a new job; otherwise sticky through DONE.
REQ-022 abort in any state: next state LOAD, counters 0, out_valid=0, ovf=0; abort wins over simultaneous in or out handshake.
REQ-023 out_data retains last delivered result after leaving DONE until next DONE.

Reset
REQ-024 resetn=0 at an edge: state LOAD, counters 0, accumulator and operand registers 0.
REQ-025 Outputs after reset: in_ready=1, out_valid=0, out_data=0, ovf=0, busy=0.
REQ-026 Reset mid-load or mid-compute discards all partial operands and results.

Configuration
REQ-027 Macro POLY_SEQ_CUBIC_EN defined: R = A*X^3 + B*X^2 + C*X + D, operands A, B, C, D, X, N_OPERANDS=5, N_STEPS=6 (adds acc=acc*X; acc=acc+D).
REQ-028 Macro undefined: quadratic form, N_OPERANDS=4, N_STEPS=4; no D register synthesised.

Structure
REQ-029 Package poly_pkg holds the state enum (LOAD, CALC, DONE), ALU op enum (OP_ADD, OP_MUL), N_OPERANDS, N_STEPS, data width 8.
REQ-030 One sub-module poly_alu: combinational 8-bit add/mul with overflow output, driven by op and operand-select from the sequencer.

Verification
REQ-031 A=2,B=3,C=4,X=5, out_ready=1 -> out_data=69, ovf=0, out_valid exactly 4 cycles after X edge, one cycle wide.
REQ-032 A=16,B=0,C=0,X=16 -> out_data=0, ovf=1; next job A=1,B=1,C=1,X=1 -> out_data=3, ovf=0.
REQ-033 Job 1,2,3,X=2 with out_ready=0 for 10 cycles -> out_valid, out_data=11 stable, in_ready=0 throughout; taken on out_ready=1.
REQ-034 abort asserted in second CALC cycle -> LOAD next cycle, out_valid never asserts, next full job correct.
REQ-035 resetn low after B accepted -> restart; job 1,1,1,X=3 -> out_data=13.
REQ-036 POLY_SEQ_CUBIC_EN: A=1,B=2,C=3,D=4,X=2 -> out_data=26, latency 6 cycles.

Source files
------------

// File: rtl/poly_pkg.sv
// Shared types and sizing for the poly_seq polynomial sequencer.
// POLY_SEQ_CUBIC_EN selects the cubic form (five operands, six ALU steps).
package poly_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 3;

`ifdef POLY_SEQ_CUBIC_EN
    localparam int unsigned N_OPERANDS = 5;
    localparam int unsigned N_STEPS    = 6;
`else
    localparam int unsigned N_OPERANDS = 4;
    localparam int unsigned N_STEPS    = 4;
`endif

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_MUL = 1'b1
    } alu_op_e;

    typedef enum logic [1:0] {
        SEL_X = 2'd0,
        SEL_B = 2'd1,
        SEL_C = 2'd2,
        SEL_D = 2'd3
    } opnd_sel_e;

    // Horner schedule: even steps multiply by X, odd steps add the next coefficient.
    function automatic alu_op_e step_op(input logic [CNT_W-1:0] step);
        return step[0] ? OP_ADD : OP_MUL;
    endfunction

    function automatic opnd_sel_e step_sel(input logic [CNT_W-1:0] step);
        case (step)
            3'd1:    return SEL_B;
            3'd3:    return SEL_C;
            3'd5:    return SEL_D;
            default: return SEL_X;
        endcase
    endfunction

endpackage

// File: rtl/poly_alu.sv
// Combinational 8-bit add/multiply with overflow flag for the poly_seq accumulator.
module poly_alu
    import poly_pkg::*;
(
    input  alu_op_e           i_op,
    input  opnd_sel_e         i_sel,
    input  logic [DATA_W-1:0] i_acc,
    input  logic [DATA_W-1:0] i_x,
    input  logic [DATA_W-1:0] i_b,
    input  logic [DATA_W-1:0] i_c,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_res,
    output logic              o_ovf
);

    logic [DATA_W-1:0]   w_opnd;
    logic [DATA_W:0]     w_sum;
    logic [2*DATA_W-1:0] w_prod;

    // Second operand selection
    always_comb begin
        w_opnd = {DATA_W{1'b0}};
        case (i_sel)
            SEL_X:   w_opnd = i_x;
            SEL_B:   w_opnd = i_b;
            SEL_C:   w_opnd = i_c;
            SEL_D:   w_opnd = i_d;
            default: w_opnd = {DATA_W{1'b0}};
        endcase
    end

    assign w_sum  = {1'b0, i_acc} + {1'b0, w_opnd};
    assign w_prod = {{DATA_W{1'b0}}, i_acc} * {{DATA_W{1'b0}}, w_opnd};

    // Result truncation and overflow detection
    always_comb begin
        o_res = {DATA_W{1'b0}};
        o_ovf = 1'b0;
        case (i_op)
            OP_ADD: begin
                o_res = w_sum[DATA_W-1:0];
                o_ovf = w_sum[DATA_W];
            end
            OP_MUL: begin
                o_res = w_prod[DATA_W-1:0];
                o_ovf = |w_prod[2*DATA_W-1:DATA_W];
            end
            default: begin
                o_res = {DATA_W{1'b0}};
                o_ovf = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/poly_seq.sv
// Handshaked polynomial evaluator (Horner form, one ALU op per cycle).
// POLY_SEQ_CUBIC_EN adds the D coefficient and the cubic term.
module poly_seq
    import poly_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              abort,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              ovf,
    output logic              busy
);

    state_e            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_opnd_cnt, w_opnd_cnt_nxt;
    logic [CNT_W-1:0]  r_step, w_step_nxt;
    logic              r_in_ready, r_out_valid, r_busy, r_ovf;
    logic [DATA_W-1:0] r_acc, r_b, r_c, r_x, r_out_data;
    logic [DATA_W-1:0] w_d, w_alu_res;
    logic              w_alu_ovf, w_in_hs, w_last_opnd, w_last_step;
    alu_op_e           w_op;
    opnd_sel_e         w_sel;

`ifdef POLY_SEQ_CUBIC_EN
    logic [DATA_W-1:0] r_d;
    assign w_d = r_d;
`else
    assign w_d = {DATA_W{1'b0}};
`endif

    assign w_in_hs     = in_valid && (r_state == LOAD);
    assign w_last_opnd = (r_opnd_cnt == CNT_W'(N_OPERANDS - 1));
    assign w_last_step = (r_step == CNT_W'(N_STEPS - 1));
    assign w_op        = step_op(r_step);
    assign w_sel       = step_sel(r_step);

    poly_alu u_alu (
        .i_op  (w_op),
        .i_sel (w_sel),
        .i_acc (r_acc),
        .i_x   (r_x),
        .i_b   (r_b),
        .i_c   (r_c),
        .i_d   (w_d),
        .o_res (w_alu_res),
        .o_ovf (w_alu_ovf)
    );

    // Next-state and counter logic; abort overrides every handshake
    always_comb begin
        w_state_nxt    = r_state;
        w_opnd_cnt_nxt = r_opnd_cnt;
        w_step_nxt     = r_step;
        if (abort) begin
            w_state_nxt    = LOAD;
            w_opnd_cnt_nxt = {CNT_W{1'b0}};
            w_step_nxt     = {CNT_W{1'b0}};
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_in_hs && w_last_opnd) begin
                        w_state_nxt    = CALC;
                        w_opnd_cnt_nxt = {CNT_W{1'b0}};
                        w_step_nxt     = {CNT_W{1'b0}};
                    end else if (w_in_hs) begin
                        w_opnd_cnt_nxt = r_opnd_cnt + CNT_W'(1);
                    end else begin
                        w_opnd_cnt_nxt = r_opnd_cnt;
                    end
                end
                CALC: begin
                    if (w_last_step) begin
                        w_state_nxt = DONE;
                        w_step_nxt  = {CNT_W{1'b0}};
                    end else begin
                        w_step_nxt  = r_step + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        w_state_nxt = LOAD;
                    end else begin
                        w_state_nxt = DONE;
                    end
                end
                default: begin
                    w_state_nxt    = LOAD;
                    w_opnd_cnt_nxt = {CNT_W{1'b0}};
                    w_step_nxt     = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // State register; handshake/status outputs are registered from the next state
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= LOAD;
            r_opnd_cnt  <= {CNT_W{1'b0}};
            r_step      <= {CNT_W{1'b0}};
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_opnd_cnt  <= w_opnd_cnt_nxt;
            r_step      <= w_step_nxt;
            r_in_ready  <= (w_state_nxt == LOAD);
            r_out_valid <= (w_state_nxt == DONE);
            r_busy      <= (w_state_nxt == CALC) || (w_state_nxt == DONE);
        end
    end

    // Operand capture, accumulator update and result/overflow registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_acc      <= {DATA_W{1'b0}};
            r_b        <= {DATA_W{1'b0}};
            r_c        <= {DATA_W{1'b0}};
            r_x        <= {DATA_W{1'b0}};
`ifdef POLY_SEQ_CUBIC_EN
            r_d        <= {DATA_W{1'b0}};
`endif
            r_out_data <= {DATA_W{1'b0}};
            r_ovf      <= 1'b0;
        end else if (abort) begin
            r_ovf      <= 1'b0;
        end else if (w_in_hs) begin
            if (w_last_opnd) begin
                r_x <= in_data;
            end else begin
                case (r_opnd_cnt)
                    3'd0: begin
                        r_acc <= in_data;
                        r_ovf <= 1'b0;
                    end
                    3'd1: r_b <= in_data;
                    3'd2: r_c <= in_data;
`ifdef POLY_SEQ_CUBIC_EN
                    3'd3: r_d <= in_data;
`endif
                    default: r_acc <= r_acc;
                endcase
            end
        end else if (r_state == CALC) begin
            r_acc <= w_alu_res;
            if (w_alu_ovf) begin
                r_ovf <= 1'b1;
            end
            if (w_last_step) begin
                r_out_data <= w_alu_res;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign ovf       = r_ovf;
    assign busy      = r_busy;

endmodule

// File: tb/tb_poly_seq.sv
// Scoreboard bench for poly_seq: directed jobs push expected results, a monitor
// pops and compares on every output handshake. Honours POLY_SEQ_CUBIC_EN.
module tb_poly_seq;

`ifdef POLY_SEQ_CUBIC_EN
    localparam int LAT = 6;
    localparam logic [7:0] E031 = 8'd89;  localparam logic O031 = 1'b1;
    localparam logic [7:0] E032A = 8'd0;  localparam logic O032A = 1'b1;
    localparam logic [7:0] E032B = 8'd3;  localparam logic O032B = 1'b0;
    localparam logic [7:0] E033 = 8'd22;  localparam logic O033 = 1'b0;
    localparam logic [7:0] E035 = 8'd39;  localparam logic O035 = 1'b0;
    localparam logic [7:0] E036 = 8'd26;  localparam logic O036 = 1'b0;
`else
    localparam int LAT = 4;
    localparam logic [7:0] E031 = 8'd69;  localparam logic O031 = 1'b0;
    localparam logic [7:0] E032A = 8'd0;  localparam logic O032A = 1'b1;
    localparam logic [7:0] E032B = 8'd3;  localparam logic O032B = 1'b0;
    localparam logic [7:0] E033 = 8'd11;  localparam logic O033 = 1'b0;
    localparam logic [7:0] E035 = 8'd13;  localparam logic O035 = 1'b0;
    localparam logic [7:0] E036 = 8'd11;  localparam logic O036 = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetn, in_valid, in_ready, abort, out_valid, out_ready, ovf, busy;
    logic [7:0] in_data, out_data;

    typedef struct packed {
        logic [7:0] data;
        logic       ovf;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    poly_seq dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .ovf       (ovf),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: a result is taken at the next edge whenever out_valid & out_ready
    always @(negedge clk) begin
        exp_t e;
        if (resetn && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: got %0d, expected no result", out_data);
            end else begin
                e = sb_q.pop_front();
                chk("out_data", out_data, e.data);
                chk("ovf", ovf, e.ovf);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] v);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = v;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_for_operand", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic load_job(input logic [7:0] a, b, c, d, x);
        send(a);
        send(b);
        send(c);
`ifdef POLY_SEQ_CUBIC_EN
        send(d);
`endif
        send(x);
    endtask

    task automatic wait_result(input string name);
        int lat;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({name, "_latency"}, lat, LAT);
    endtask

    task automatic run_job(input logic [7:0] a, b, c, d, x, input logic [7:0] e,
                           input logic eo, input string name);
        sb_q.push_back('{data: e, ovf: eo});
        load_job(a, b, c, d, x);
        wait_result(name);
        tick();
        chk({name, "_one_wide"}, out_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int n;
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        abort     = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_busy", busy, 0);
        resetn = 1'b1;
        tick();

        run_job(8'd2, 8'd3, 8'd4, 8'd0, 8'd5, E031, O031, "t031");
        chk("t031_data_retained", out_data, E031);
        chk("t031_idle_busy", busy, 0);

        run_job(8'd16, 8'd0, 8'd0, 8'd0, 8'd16, E032A, O032A, "t032a");
        run_job(8'd1, 8'd1, 8'd1, 8'd0, 8'd1, E032B, O032B, "t032b");

        // Consumer stalls for 10 cycles; in_valid offered meanwhile must be ignored
        out_ready = 1'b0;
        sb_q.push_back('{data: E033, ovf: O033});
        load_job(8'd1, 8'd2, 8'd3, 8'd0, 8'd2);
        wait_result("t033");
        in_valid = 1'b1;
        in_data  = 8'hAA;
        for (int i = 0; i < 10; i++) begin
            chk("t033_hold_valid", out_valid, 1);
            chk("t033_hold_data", out_data, E033);
            chk("t033_hold_in_ready", in_ready, 0);
            chk("t033_hold_ovf", ovf, O033);
            chk("t033_hold_busy", busy, 1);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("t033_taken", out_valid, 0);
        chk("t033_back_to_load", in_ready, 1);

        // Abort in the second CALC cycle
        load_job(8'd1, 8'd2, 8'd3, 8'd0, 8'd2);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t034_load_in_ready", in_ready, 1);
        chk("t034_busy", busy, 0);
        chk("t034_ovf", ovf, 0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("t034_no_out_valid", seen, 0);
        run_job(8'd2, 8'd3, 8'd4, 8'd0, 8'd5, E031, O031, "t034_next");

        // Reset after A and B accepted
        send(8'd1);
        send(8'd2);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk("t035_rst_out_data", out_data, 0);
        chk("t035_rst_in_ready", in_ready, 1);
        chk("t035_rst_ovf", ovf, 0);
        run_job(8'd1, 8'd1, 8'd1, 8'd0, 8'd3, E035, O035, "t035");

        run_job(8'd1, 8'd2, 8'd3, 8'd4, 8'd2, E036, O036, "t036");

        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
